// File: rtl/dual_cam_wr_arbiter_if.sv
// Bundle between the two camera capture channels and the frame-buffer write port.
// Optional drop counters appear when ARB_DROP_CNT_EN is defined.
interface dual_cam_wr_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic [1:0]        cam_en;
    logic              cam0_we;
    logic [ADDR_W-1:0] cam0_addr;
    logic [11:0]       cam0_data;
    logic              cam1_we;
    logic [ADDR_W-1:0] cam1_addr;
    logic [11:0]       cam1_data;
    logic              err_clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              busy;
    logic [1:0]        ovf;
    logic [1:0]        range_err;
`ifdef ARB_DROP_CNT_EN
    logic [15:0]       drop_cnt0;
    logic [15:0]       drop_cnt1;

    modport master (
        output cam_en, cam0_we, cam0_addr, cam0_data, cam1_we, cam1_addr, cam1_data, err_clr,
        input  wr_en, wr_addr, wr_data, busy, ovf, range_err, drop_cnt0, drop_cnt1
    );
    modport slave (
        input  cam_en, cam0_we, cam0_addr, cam0_data, cam1_we, cam1_addr, cam1_data, err_clr,
        output wr_en, wr_addr, wr_data, busy, ovf, range_err, drop_cnt0, drop_cnt1
    );
`else
    modport master (
        output cam_en, cam0_we, cam0_addr, cam0_data, cam1_we, cam1_addr, cam1_data, err_clr,
        input  wr_en, wr_addr, wr_data, busy, ovf, range_err
    );
    modport slave (
        input  cam_en, cam0_we, cam0_addr, cam0_data, cam1_we, cam1_addr, cam1_data, err_clr,
        output wr_en, wr_addr, wr_data, busy, ovf, range_err
    );
`endif
endinterface

// File: rtl/dual_cam_wr_arbiter.sv
// Two per-camera FIFOs feeding one frame-buffer write port through a round-robin arbiter.
// Define ARB_DROP_CNT_EN to add saturating per-camera dropped-pixel counters.
module dual_cam_wr_arbiter #(
    parameter int FRAME_PIXELS = 307200,
    parameter int CAM1_BASE    = 307201,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 20
) (
    input logic                 pclk,
    input logic                 rst,
    dual_cam_wr_arbiter_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + 12;

    logic [1:0]        cam_we;
    logic [ADDR_W-1:0] cam_addr [2];
    logic [11:0]       cam_data [2];

    logic [EW-1:0]     mem_q [2][FIFO_DEPTH];
    logic [EW-1:0]     mem_d [2][FIFO_DEPTH];
    logic [PW-1:0]     wp_q [2], wp_d [2], rp_q [2], rp_d [2];
    logic [CW-1:0]     cnt_q [2], cnt_d [2];
    logic              last_q, last_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic [1:0]        ovf_q, ovf_d, rerr_q, rerr_d;

    logic [1:0]        elig, pop, push, range_hit, ovf_hit;
    logic              gnt_valid, gnt_sel;
    logic [EW-1:0]     head;

    assign cam_we      = {bus.cam1_we, bus.cam0_we};
    assign cam_addr[0] = bus.cam0_addr;
    assign cam_addr[1] = bus.cam1_addr;
    assign cam_data[0] = bus.cam0_data;
    assign cam_data[1] = bus.cam1_data;

    // A disabled camera is never granted; its FIFO is being flushed instead.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            elig[n] = bus.cam_en[n] && (cnt_q[n] != '0);
        end
        gnt_valid = |elig;
        gnt_sel   = (&elig) ? ~last_q : elig[1];
        pop       = {gnt_valid & gnt_sel, gnt_valid & ~gnt_sel};
        last_d    = gnt_valid ? gnt_sel : last_q;
        head      = mem_q[gnt_sel][rp_q[gnt_sel]];
    end

    always_comb begin
        wr_en_d   = gnt_valid;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (gnt_valid) begin
            wr_data_d = head[11:0];
            wr_addr_d = gnt_sel ? head[EW-1:12] + ADDR_W'(CAM1_BASE) : head[EW-1:12];
        end
    end

    // A full FIFO popped in the same cycle still accepts the push.
    always_comb begin
        mem_d = mem_q;
        for (int n = 0; n < 2; n++) begin
            range_hit[n] = cam_we[n] && bus.cam_en[n] && (cam_addr[n] > ADDR_W'(FRAME_PIXELS));
            ovf_hit[n]   = cam_we[n] && bus.cam_en[n] && !range_hit[n]
                           && (cnt_q[n] == CW'(FIFO_DEPTH)) && !pop[n];
            push[n]      = cam_we[n] && bus.cam_en[n] && !range_hit[n] && !ovf_hit[n];
            wp_d[n]  = wp_q[n];
            rp_d[n]  = rp_q[n];
            cnt_d[n] = cnt_q[n];
            if (!bus.cam_en[n]) begin
                wp_d[n]  = '0;
                rp_d[n]  = '0;
                cnt_d[n] = '0;
            end else begin
                if (push[n]) begin
                    mem_d[n][wp_q[n]] = {cam_addr[n], cam_data[n]};
                    wp_d[n] = wp_q[n] + PW'(1);
                end
                if (pop[n]) begin
                    rp_d[n] = rp_q[n] + PW'(1);
                end
                cnt_d[n] = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
            end
        end
        ovf_d  = (bus.err_clr ? 2'b00 : ovf_q) | ovf_hit;
        rerr_d = (bus.err_clr ? 2'b00 : rerr_q) | range_hit;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                wp_q[n]  <= '0;
                rp_q[n]  <= '0;
                cnt_q[n] <= '0;
            end
            last_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= '0;
            rerr_q    <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                wp_q[n]  <= wp_d[n];
                rp_q[n]  <= rp_d[n];
                cnt_q[n] <= cnt_d[n];
            end
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
            rerr_q    <= rerr_d;
        end
    end

    always_ff @(posedge pclk) begin
        mem_q <= mem_d;
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (cnt_q[0] != '0) || (cnt_q[1] != '0);
    assign bus.ovf       = ovf_q;
    assign bus.range_err = rerr_q;

`ifdef ARB_DROP_CNT_EN
    logic [15:0] dcnt_q [2], dcnt_d [2];
    logic [1:0]  drop;

    // err_clr wins over the old count, but a drop in the same cycle still counts once.
    always_comb begin
        drop = range_hit | ovf_hit;
        for (int n = 0; n < 2; n++) begin
            dcnt_d[n] = dcnt_q[n];
            if (bus.err_clr) begin
                dcnt_d[n] = drop[n] ? 16'd1 : 16'd0;
            end else if (drop[n] && (dcnt_q[n] != 16'hFFFF)) begin
                dcnt_d[n] = dcnt_q[n] + 16'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            dcnt_q[0] <= '0;
            dcnt_q[1] <= '0;
        end else begin
            dcnt_q[0] <= dcnt_d[0];
            dcnt_q[1] <= dcnt_d[1];
        end
    end

    assign bus.drop_cnt0 = dcnt_q[0];
    assign bus.drop_cnt1 = dcnt_q[1];
`endif
endmodule

// File: tb/tb_dual_cam_wr_arbiter.sv
// Randomized and directed bench for dual_cam_wr_arbiter against a queue-based reference model.
module tb_dual_cam_wr_arbiter;
    localparam int FRAME = 307200;
    localparam int BASE  = 307201;
    localparam int DEPTH = 4;
    localparam int AW    = 20;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    dual_cam_wr_arbiter_if #(.ADDR_W(AW)) ifc ();

    dual_cam_wr_arbiter #(
        .FRAME_PIXELS(FRAME), .CAM1_BASE(BASE), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (ifc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of {addr,data} per camera, updated once per rising edge.
    logic [31:0]   mq0 [$];
    logic [31:0]   mq1 [$];
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [11:0]   m_data = '0;
    logic          m_busy = 1'b0;
    logic [1:0]    m_ovf = '0, m_rerr = '0;
    int            m_last = 1;
    logic          e0, e1;
    int            g;
    logic [31:0]   h;
    logic [1:0]    rset, oset;

    always @(posedge pclk) begin
        if (rst) begin
            mq0.delete(); mq1.delete();
            m_en = 0; m_addr = '0; m_data = '0; m_ovf = '0; m_rerr = '0; m_last = 1;
        end else begin
            e0 = ifc.cam_en[0] && (mq0.size() > 0);
            e1 = ifc.cam_en[1] && (mq1.size() > 0);
            if (e0 || e1) begin
                g = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
                h = (g == 1) ? mq1.pop_front() : mq0.pop_front();
                m_en = 1; m_data = h[11:0];
                m_addr = (g == 1) ? AW'(int'(h[31:12]) + BASE) : h[31:12];
                m_last = g;
            end else begin
                m_en = 0;
            end
            rset = '0; oset = '0;
            if (!ifc.cam_en[0]) mq0.delete();
            else if (ifc.cam0_we) begin
                if (int'(ifc.cam0_addr) > FRAME) rset[0] = 1;
                else if (mq0.size() >= DEPTH) oset[0] = 1;
                else mq0.push_back({12'h0, ifc.cam0_addr, ifc.cam0_data} & 32'hFFFF_FFFF);
            end
            if (!ifc.cam_en[1]) mq1.delete();
            else if (ifc.cam1_we) begin
                if (int'(ifc.cam1_addr) > FRAME) rset[1] = 1;
                else if (mq1.size() >= DEPTH) oset[1] = 1;
                else mq1.push_back({12'h0, ifc.cam1_addr, ifc.cam1_data} & 32'hFFFF_FFFF);
            end
            m_ovf  = (ifc.err_clr ? 2'b00 : m_ovf) | oset;
            m_rerr = (ifc.err_clr ? 2'b00 : m_rerr) | rset;
        end
        m_busy = (mq0.size() > 0) || (mq1.size() > 0);
    end

    logic [37:0] dut_v, exp_v;
    assign dut_v = {ifc.wr_en, ifc.wr_addr, ifc.wr_data, ifc.busy, ifc.ovf, ifc.range_err};
    assign exp_v = {m_en, m_addr, m_data, m_busy, m_ovf, m_rerr};

    task automatic set_in(input logic [1:0] en, input logic w0, input int a0, input int d0,
                          input logic w1, input int a1, input int d1, input logic clr);
        ifc.cam_en    = en;
        ifc.cam0_we   = w0; ifc.cam0_addr = AW'(a0); ifc.cam0_data = 12'(d0);
        ifc.cam1_we   = w1; ifc.cam1_addr = AW'(a1); ifc.cam1_data = 12'(d1);
        ifc.err_clr   = clr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge pclk);
        checks++;
        if (dut_v !== 38'h0) begin
            errors++; $display("FAIL reset_state got %h exp 0", dut_v);
        end
        checks++;
        if (dut_v !== exp_v) begin
            errors++; $display("FAIL model_reset got %h exp %h", dut_v, exp_v);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_cam();
        set_in(2'b01, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 20; j++) begin
            @(negedge pclk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL model_single j=%0d got %h exp %h", j, dut_v, exp_v);
            end
            checks++;
            if (j >= 2 && (j % 2) == 0 && (j - 2) / 2 < 8) begin
                if (!(ifc.wr_en === 1'b1 && ifc.wr_addr === AW'((j - 2) / 2 + 1)
                      && ifc.wr_data === 12'(32'h100 + (j - 2) / 2))) begin
                    errors++;
                    $display("FAIL single_write j=%0d got en=%b addr=%0d data=%h exp addr=%0d data=%h",
                             j, ifc.wr_en, ifc.wr_addr, ifc.wr_data, (j - 2) / 2 + 1, 32'h100 + (j - 2) / 2);
                end
            end else if (ifc.wr_en !== 1'b0) begin
                errors++; $display("FAIL single_idle j=%0d got wr_en=%b exp 0", j, ifc.wr_en);
            end
            if ((j % 2) == 0 && j / 2 < 8) set_in(2'b01, 1, j / 2 + 1, 32'h100 + j / 2, 0, 0, 0, 0);
            else set_in(2'b01, 0, 0, 0, 0, 0, 0, 0);
        end
        checks++;
        if (ifc.ovf !== 2'b00) begin
            errors++; $display("FAIL single_ovf got %b exp 00", ifc.ovf);
        end
    endtask

    task automatic test_dual_contention();
        rst = 1'b1;
        set_in(2'b11, 0, 0, 0, 0, 0, 0, 0);
        @(negedge pclk);
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge pclk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL model_dual j=%0d got %h exp %h", j, dut_v, exp_v);
            end
            if (j == 2 || j == 3) begin
                checks++;
                if (!(ifc.wr_en === 1'b1 && ifc.wr_addr === AW'(j == 2 ? 5 : 307206)
                      && ifc.wr_data === (j == 2 ? 12'hAAA : 12'h555))) begin
                    errors++;
                    $display("FAIL dual_order j=%0d got en=%b addr=%0d data=%h",
                             j, ifc.wr_en, ifc.wr_addr, ifc.wr_data);
                end
            end
            if (j == 0) set_in(2'b11, 1, 5, 12'hAAA, 1, 5, 12'h555, 0);
            else if (j == 4) set_in(2'b11, 1, 7, 12'h123, 1, 7, 12'h456, 0);
            else set_in(2'b11, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_overflow();
        for (int j = 0; j < 14; j++) begin
            @(negedge pclk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL model_ovf j=%0d got %h exp %h", j, dut_v, exp_v);
            end
            set_in(2'b11, 1, 100 + j, j, 1, 200 + j, 32'h10 + j, 0);
        end
        @(negedge pclk);
        checks++;
        if (ifc.ovf[1] !== 1'b1) begin
            errors++; $display("FAIL ovf_set got %b exp 1x", ifc.ovf);
        end
        set_in(2'b11, 0, 0, 0, 0, 0, 0, 1);
        @(negedge pclk);
        checks++;
        if (ifc.ovf !== 2'b00 || dut_v !== exp_v) begin
            errors++; $display("FAIL ovf_clr got %b exp 00", ifc.ovf);
        end
        set_in(2'b11, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 10; j++) begin
            @(negedge pclk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL model_drain j=%0d got %h exp %h", j, dut_v, exp_v);
            end
        end
    endtask

    task automatic test_range();
        set_in(2'b01, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 7; j++) begin
            @(negedge pclk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL model_range j=%0d got %h exp %h", j, dut_v, exp_v);
            end
            checks++;
            if (j == 1 && (ifc.range_err !== 2'b01 || ifc.busy !== 1'b0)) begin
                errors++; $display("FAIL range_set got %b busy=%b exp 01 busy=0", ifc.range_err, ifc.busy);
            end else if ((j == 2 || j == 3) && ifc.wr_en !== 1'b0) begin
                errors++; $display("FAIL range_drop got wr_en=%b exp 0", ifc.wr_en);
            end else if (j == 4 && !(ifc.wr_en === 1'b1 && ifc.wr_addr === AW'(FRAME)
                                     && ifc.wr_data === 12'h321)) begin
                errors++; $display("FAIL range_edge got en=%b addr=%0d exp addr=%0d", ifc.wr_en, ifc.wr_addr, FRAME);
            end else if (j == 6 && ifc.range_err !== 2'b11) begin
                errors++; $display("FAIL range_cam1 got %b exp 11", ifc.range_err);
            end
            if (j == 0) set_in(2'b01, 1, FRAME + 1, 12'hABC, 0, 0, 0, 0);
            else if (j == 2) set_in(2'b01, 1, FRAME, 12'h321, 0, 0, 0, 0);
            else if (j == 5) set_in(2'b11, 0, 0, 0, 1, FRAME + 5, 12'h777, 0);
            else set_in(2'b11, 0, 0, 0, 0, 0, 0, 0);
        end
        set_in(2'b11, 0, 0, 0, 0, 0, 0, 1);
        @(negedge pclk);
        set_in(2'b11, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_disable_flush();
        rst = 1'b1;
        set_in(2'b11, 0, 0, 0, 0, 0, 0, 0);
        @(negedge pclk);
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge pclk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL model_fill j=%0d got %h exp %h", j, dut_v, exp_v);
            end
            if (j < 4) set_in(2'b11, 1, 10 + j, j, 1, 20 + j, 32'h20 + j, 0);
            else set_in(2'b01, 0, 0, 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL model_flush k=%0d got %h exp %h", k, dut_v, exp_v);
            end
            checks++;
            if (ifc.wr_en === 1'b1 && int'(ifc.wr_addr) >= BASE) begin
                errors++; $display("FAIL flush_stale k=%0d got addr=%0d exp < %0d", k, ifc.wr_addr, BASE);
            end
            if (k == 1) begin
                checks++;
                if (ifc.busy !== 1'b0) begin
                    errors++; $display("FAIL flush_busy got %b exp 0", ifc.busy);
                end
            end
        end
        set_in(2'b11, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge pclk);
        checks++;
        if (ifc.busy !== 1'b0 || dut_v !== exp_v) begin
            errors++; $display("FAIL reenable_busy got %b exp 0", ifc.busy);
        end
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 6; j++) begin
            @(negedge pclk);
            set_in(2'b11, 1, 300 + j, j, 1, 400 + j, j, 0);
        end
        rst = 1'b1;
        set_in(2'b11, 0, 0, 0, 0, 0, 0, 0);
        @(negedge pclk);
        checks++;
        if (ifc.wr_en !== 1'b0 || ifc.busy !== 1'b0 || ifc.ovf !== 2'b00) begin
            errors++; $display("FAIL reset_mid got en=%b busy=%b ovf=%b exp 0 0 00", ifc.wr_en, ifc.busy, ifc.ovf);
        end
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge pclk);
            checks++;
            if (ifc.wr_en !== 1'b0 || dut_v !== exp_v) begin
                errors++; $display("FAIL reset_stale j=%0d got %h exp %h", j, dut_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] en = 2'b11;
        logic p0 = 0, p1 = 0, w0, w1, stress, r;
        int a0, a1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge pclk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++; $display("FAIL model_rand c=%0d got %h exp %h", c, dut_v, exp_v);
            end
            stress = ((c / 200) % 3) == 2;
            if ($urandom_range(0, 63) == 0) en[$urandom_range(0, 1)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) en = 2'b11;
            w0 = stress ? ($urandom_range(0, 3) != 0) : (!p0 && $urandom_range(0, 1) == 1);
            w1 = stress ? ($urandom_range(0, 3) != 0) : (!p1 && $urandom_range(0, 1) == 1);
            p0 = w0; p1 = w1;
            case ($urandom_range(0, 15))
                0: a0 = FRAME + 1 + $urandom_range(0, 1000);
                1: a0 = FRAME;
                default: a0 = $urandom_range(0, FRAME);
            endcase
            case ($urandom_range(0, 15))
                0: a1 = FRAME + 1 + $urandom_range(0, 1000);
                1: a1 = 0;
                default: a1 = $urandom_range(0, FRAME);
            endcase
            r = ($urandom_range(0, 499) == 0);
            rst = r;
            set_in(en, w0, a0, $urandom_range(0, 4095), w1, a1, $urandom_range(0, 4095),
                   $urandom_range(0, 49) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_single_cam();
        test_dual_contention();
        test_overflow();
        test_range();
        test_disable_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
